// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the two-port memory arbiter.
// Port 0 is the CPU load/store/fetch path, port 1 the program loader/debug path.
// master = requester side, slave = arbiter side.
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_ack;
   logic [DATA_W-1:0] p0_rdata;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_ack;
   logic [DATA_W-1:0] p1_rdata;

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p0_ack, p0_rdata, p1_ack, p1_rdata
   );

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p0_ack, p0_rdata, p1_ack, p1_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a 256x8 data memory.
// Each access takes three cycles: arbitrate/latch, memory access, acknowledge.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; requests sampled and winner latched
// ACCESS | memory driven with latched operands; read data captured
// RESP   | one-cycle ack pulse to the winning port
module mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   mem_arbiter_if.slave      bus,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_we,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy,
   output logic              o_grant
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              w_start;
   logic              w_win;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   logic              r_grant;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_p0_ack;
   logic              r_p1_ack;
   logic [DATA_W-1:0] r_p0_rdata;
   logic [DATA_W-1:0] r_p1_rdata;

   // Next-state and winner selection; on a tie the port that did not win last time goes.
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_win        = r_grant;
      case (r_state)
         IDLE: begin
            if (bus.p0_req || bus.p1_req) begin
               w_start      = 1'b1;
               w_next_state = ACCESS;
               if (bus.p0_req && bus.p1_req) begin
                  w_win = ~r_grant;
               end else begin
                  w_win = bus.p1_req;
               end
            end
         end
         ACCESS:  w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Operand mux for the winning port, used only when latching in IDLE.
   always_comb begin
      w_sel_we    = w_win ? bus.p1_we    : bus.p0_we;
      w_sel_addr  = w_win ? bus.p1_addr  : bus.p0_addr;
      w_sel_wdata = w_win ? bus.p1_wdata : bus.p0_wdata;
   end

   // State register, operand latch, ack pulse and per-port read data capture.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_grant    <= 1'b1;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_p0_ack   <= 1'b0;
         r_p1_ack   <= 1'b0;
         r_p0_rdata <= '0;
         r_p1_rdata <= '0;
      end else begin
         r_state  <= w_next_state;
         r_p0_ack <= 1'b0;
         r_p1_ack <= 1'b0;
         if (w_start) begin
            r_grant <= w_win;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
         end
         if (r_state == ACCESS) begin
            if (r_grant) begin
               r_p1_ack <= 1'b1;
               if (!r_we) r_p1_rdata <= i_mem_rdata;
            end else begin
               r_p0_ack <= 1'b1;
               if (!r_we) r_p0_rdata <= i_mem_rdata;
            end
         end
      end
   end

   // Memory address/data always come from the latch so the bus never follows live inputs.
   assign o_mem_addr   = r_addr;
   assign o_mem_wdata  = r_wdata;
   assign o_mem_we     = (r_state == ACCESS) && r_we;
   assign o_busy       = (r_state != IDLE);
   assign o_grant      = r_grant;
   assign bus.p0_ack   = r_p0_ack;
   assign bus.p1_ack   = r_p1_ack;
   assign bus.p0_rdata = r_p0_rdata;
   assign bus.p1_rdata = r_p1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (3-cycle service, round-robin on ties, serialized memory).
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we, busy, grant;

   logic [7:0] mem [256];
   bit         mem_ready = 1'b0;
   logic [7:0] ref_mem [256];

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .bus         (bus),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_mem_we    (mem_we),
      .i_mem_rdata (mem_rdata),
      .o_busy      (busy),
      .o_grant     (grant)
   );

   function automatic logic [7:0] init_val(int i);
      if (i == 200) return 8'h05;
      if (i == 201) return 8'h0A;
      return 8'((i * 37 + 11) & 255);
   endfunction

   // Memory: combinational read, write on rising edge, no reset.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
         mem_ready <= 1'b1;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ports();
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 8'h00; bus.p0_wdata = 8'h00;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 8'h00; bus.p1_wdata = 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_ports();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({busy, grant, bus.p0_ack, bus.p1_ack, mem_we} !== 5'b01000) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy/grant/ack0/ack1/we got %b expected 01000",
                  {busy, grant, bus.p0_ack, bus.p1_ack, mem_we});
      end
      n_tests++;
      if (bus.p0_rdata !== 8'h00 || bus.p1_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h/%h expected 00/00", bus.p0_rdata, bus.p1_rdata);
      end
      n_tests++;
      if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_latch: addr/wdata got %h/%h expected 00/00", mem_addr, mem_wdata);
      end
   endtask

   task automatic test_p0_read();
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 8'd200;
      for (int c = 1; c <= 4; c++) begin
         tick();
         n_tests++;
         if (bus.p0_ack !== (c == 2) || bus.p1_ack !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL p0_read_cycle%0d: ack0/ack1/we got %b%b%b expected %b00",
                     c, bus.p0_ack, bus.p1_ack, mem_we, (c == 2));
         end
         if (c == 2) begin
            n_tests++;
            if (bus.p0_rdata !== 8'h05) begin
               n_fail++;
               $display("FAIL p0_read_data: got %h expected 05", bus.p0_rdata);
            end
            bus.p0_req = 1'b0;
         end
      end
      n_tests++;
      if (bus.p1_rdata !== 8'h00 || grant !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL p0_read_after: p1_rdata/grant/busy got %h/%b/%b expected 00/0/0",
                  bus.p1_rdata, grant, busy);
      end
   endtask

   task automatic test_write_then_read();
      bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 8'd100; bus.p1_wdata = 8'hA5;
      for (int c = 1; c <= 4; c++) begin
         tick();
         n_tests++;
         if (mem_we !== (c == 1) || bus.p1_ack !== (c == 2) || bus.p0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_cycle%0d: we/ack1/ack0 got %b%b%b expected %b%b0",
                     c, mem_we, bus.p1_ack, bus.p0_ack, (c == 1), (c == 2));
         end
         if (c == 1) begin
            n_tests++;
            if (mem_addr !== 8'd100 || mem_wdata !== 8'hA5) begin
               n_fail++;
               $display("FAIL wr_bus: addr/wdata got %h/%h expected 64/a5", mem_addr, mem_wdata);
            end
         end
         if (c == 2) begin
            bus.p1_req = 1'b0;
            bus.p1_we  = 1'b0;
         end
      end
      ref_mem[100] = 8'hA5;
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 8'd100;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 2) begin
            n_tests++;
            if (bus.p0_ack !== 1'b1 || bus.p0_rdata !== 8'hA5) begin
               n_fail++;
               $display("FAIL wr_readback: ack/rdata got %b/%h expected 1/a5", bus.p0_ack, bus.p0_rdata);
            end
            bus.p0_req = 1'b0;
         end
      end
      n_tests++;
      if (bus.p1_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL wr_p1_rdata_kept: got %h expected 00", bus.p1_rdata);
      end
   endtask

   task automatic test_addr_change();
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 8'd50; bus.p0_wdata = 8'h11;
      tick();
      bus.p0_addr = 8'd51; bus.p0_we = 1'b1; bus.p0_wdata = 8'h99;
      #1;
      n_tests++;
      if (mem_addr !== 8'd50 || mem_wdata !== 8'h11 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL addr_change_bus: addr/wdata/we got %h/%h/%b expected 32/11/0",
                  mem_addr, mem_wdata, mem_we);
      end
      tick();
      n_tests++;
      if (bus.p0_ack !== 1'b1 || bus.p0_rdata !== ref_mem[50] || mem_addr !== 8'd50) begin
         n_fail++;
         $display("FAIL addr_change_data: ack/rdata/addr got %b/%h/%h expected 1/%h/32",
                  bus.p0_ack, bus.p0_rdata, mem_addr, ref_mem[50]);
      end
      bus.p0_req = 1'b0; bus.p0_we = 1'b0;
      tick();
      n_tests++;
      if (mem[51] !== ref_mem[51] || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL addr_change_nowrite: mem51/busy got %h/%b expected %h/0", mem[51], busy, ref_mem[51]);
      end
   endtask

   task automatic test_back_to_back();
      bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 8'd255; bus.p0_wdata = 8'hFF;
      for (int c = 1; c <= 6; c++) begin
         tick();
         n_tests++;
         if (bus.p0_ack !== (c == 2 || c == 5) || mem_we !== (c == 1)) begin
            n_fail++;
            $display("FAIL b2b_cycle%0d: ack0/we got %b%b expected %b%b",
                     c, bus.p0_ack, mem_we, (c == 2 || c == 5), (c == 1));
         end
         if (c == 2) bus.p0_we = 1'b0;
         if (c == 4) begin
            n_tests++;
            if (mem_addr !== 8'd255 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_second: addr/busy got %h/%b expected ff/1", mem_addr, busy);
            end
         end
         if (c == 5) begin
            n_tests++;
            if (bus.p0_rdata !== 8'hFF) begin
               n_fail++;
               $display("FAIL b2b_rdata: got %h expected ff", bus.p0_rdata);
            end
            bus.p0_req = 1'b0;
         end
      end
      ref_mem[255] = 8'hFF;
   endtask

   task automatic test_round_robin();
      int k, ph;
      logic ep;
      do_reset();
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 8'd200;
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 8'd201;
      for (int c = 1; c <= 12; c++) begin
         tick();
         k  = (c - 1) / 3;
         ph = (c - 1) % 3;
         ep = (k % 2 == 1);
         if (c <= 11 && ph == 0) begin
            n_tests++;
            if (grant !== ep || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL rr_grant%0d: grant/busy got %b/%b expected %b/1", k, grant, busy, ep);
            end
         end
         n_tests++;
         if (bus.p0_ack !== (ph == 1 && !ep) || bus.p1_ack !== (ph == 1 && ep)) begin
            n_fail++;
            $display("FAIL rr_ack_cycle%0d: ack0/ack1 got %b%b expected %b%b",
                     c, bus.p0_ack, bus.p1_ack, (ph == 1 && !ep), (ph == 1 && ep));
         end
         if (c == 11) begin
            bus.p0_req = 1'b0;
            bus.p1_req = 1'b0;
         end
      end
      n_tests++;
      if (bus.p0_rdata !== 8'h05 || bus.p1_rdata !== 8'h0A) begin
         n_fail++;
         $display("FAIL rr_rdata: got %h/%h expected 05/0a", bus.p0_rdata, bus.p1_rdata);
      end
   endtask

   task automatic test_reset_mid();
      bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 8'd7; bus.p0_wdata = 8'h77;
      tick();
      rst_n = 1'b0;
      bus.p0_req = 1'b0; bus.p0_we = 1'b0;
      tick();
      n_tests++;
      if (mem[7] !== 8'h77 || bus.p0_ack !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_access_write: mem7/ack0/busy got %h/%b/%b expected 77/0/0",
                  mem[7], bus.p0_ack, busy);
      end
      ref_mem[7] = 8'h77;
      rst_n = 1'b1;
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 8'd201;
      tick();
      tick();
      n_tests++;
      if (bus.p1_ack !== 1'b1 || bus.p1_rdata !== 8'h0A) begin
         n_fail++;
         $display("FAIL rst_pre_resp: ack1/rdata1 got %b/%h expected 1/0a", bus.p1_ack, bus.p1_rdata);
      end
      rst_n = 1'b0;
      bus.p1_req = 1'b0;
      tick();
      n_tests++;
      if ({bus.p1_ack, busy, grant} !== 3'b001 || bus.p1_rdata !== 8'h00 || bus.p0_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_in_resp: ack1/busy/grant got %b rdata %h/%h expected 001 00/00",
                  {bus.p1_ack, busy, grant}, bus.p0_rdata, bus.p1_rdata);
      end
      rst_n = 1'b1;
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 8'd200;
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 8'd201;
      tick();
      n_tests++;
      if (grant !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_first_tie: grant/busy got %b/%b expected 0/1", grant, busy);
      end
      tick();
      n_tests++;
      if (bus.p0_ack !== 1'b1 || bus.p1_ack !== 1'b0 || bus.p0_rdata !== 8'h05) begin
         n_fail++;
         $display("FAIL rst_first_tie_ack: ack0/ack1/rdata got %b/%b/%h expected 1/0/05",
                  bus.p0_ack, bus.p1_ack, bus.p0_rdata);
      end
      idle_ports();
      tick();
   endtask

   // Transaction-level model: a request is served at the first edge at least
   // three edges after the previous start; ack is seen one edge after start.
   task automatic test_random();
      logic       rq [2];
      logic       rw [2];
      logic [7:0] ra [2];
      logic [7:0] rd [2];
      logic [7:0] exp_rdata [2];
      int         a;
      logic       ap, awe, w, exp_grant;
      logic [7:0] exp_addr, exp_wd, rd_val;
      logic       e_ack0, e_ack1, e_busy, e_we;
      do_reset();
      a = -10; ap = 1'b0; awe = 1'b0; exp_grant = 1'b1;
      exp_addr = 8'h00; exp_wd = 8'h00; rd_val = 8'h00;
      for (int p = 0; p < 2; p++) begin
         rq[p] = 1'b0; rw[p] = 1'b0; ra[p] = 8'h00; rd[p] = 8'h00; exp_rdata[p] = 8'h00;
      end
      for (int e = 1; e <= 600; e++) begin
         bus.p0_req = rq[0]; bus.p0_we = rw[0]; bus.p0_addr = ra[0]; bus.p0_wdata = rd[0];
         bus.p1_req = rq[1]; bus.p1_we = rw[1]; bus.p1_addr = ra[1]; bus.p1_wdata = rd[1];
         if (e >= a + 3 && (rq[0] || rq[1])) begin
            if (rq[0] && rq[1]) w = (exp_grant == 1'b1) ? 1'b0 : 1'b1;
            else if (rq[0])     w = 1'b0;
            else                w = 1'b1;
            a = e; ap = w; awe = rw[w];
            exp_grant = w; exp_addr = ra[w]; exp_wd = rd[w];
            if (rw[w]) ref_mem[ra[w]] = rd[w];
            else       rd_val = ref_mem[ra[w]];
         end
         tick();
         if (e == a + 1 && !awe) exp_rdata[ap] = rd_val;
         e_ack0 = (e == a + 1) && !ap;
         e_ack1 = (e == a + 1) && ap;
         e_busy = (e == a) || (e == a + 1);
         e_we   = (e == a) && awe;
         n_tests++;
         if ({bus.p0_ack, bus.p1_ack, busy, mem_we, grant} !== {e_ack0, e_ack1, e_busy, e_we, exp_grant}) begin
            n_fail++;
            $display("FAIL rand_ctrl e=%0d: ack0/ack1/busy/we/grant got %b expected %b",
                     e, {bus.p0_ack, bus.p1_ack, busy, mem_we, grant},
                     {e_ack0, e_ack1, e_busy, e_we, exp_grant});
         end
         n_tests++;
         if (mem_addr !== exp_addr || mem_wdata !== exp_wd) begin
            n_fail++;
            $display("FAIL rand_bus e=%0d: addr/wdata got %h/%h expected %h/%h",
                     e, mem_addr, mem_wdata, exp_addr, exp_wd);
         end
         n_tests++;
         if (bus.p0_rdata !== exp_rdata[0] || bus.p1_rdata !== exp_rdata[1]) begin
            n_fail++;
            $display("FAIL rand_rdata e=%0d: got %h/%h expected %h/%h",
                     e, bus.p0_rdata, bus.p1_rdata, exp_rdata[0], exp_rdata[1]);
         end
         for (int p = 0; p < 2; p++) begin
            if (e == a && int'(ap) == p) begin
               rw[p] = 1'($urandom_range(0, 1));
               ra[p] = 8'($urandom);
               rd[p] = 8'($urandom);
            end else if (e == a + 1 && int'(ap) == p) begin
               rq[p] = ($urandom_range(0, 2) != 0);
               rw[p] = 1'($urandom_range(0, 1));
               ra[p] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
               rd[p] = 8'($urandom);
            end else if (!rq[p] && $urandom_range(0, 2) == 0) begin
               rq[p] = 1'b1;
               rw[p] = 1'($urandom_range(0, 1));
               ra[p] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
               rd[p] = 8'($urandom);
            end
         end
      end
      idle_ports();
      tick();
      tick();
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_ports();
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      test_reset();
      test_p0_read();
      test_write_then_read();
      test_addr_change();
      test_back_to_back();
      test_round_robin();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single 256x8 data memory (combinational read, write on rising clk) between two requesters.
- Port 0 is the CPU load/store/fetch path; port 1 is the program loader/debug path.
- Serialises accesses with a req/ack handshake and round-robin fairness, and returns registered read data to the winning port.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active low
- p0_req  in  1  port 0 request; held high until p0_ack
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_ack  out  1  port 0 one-cycle completion pulse
- p0_rdata  out  DATA_W  port 0 read data, valid while p0_ack high and held until next port 0 read completes
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory combinational read data
- busy  out  1  high in any state other than IDLE
- grant  out  1  index of current/last granted port

Behaviour:
- Reset (rst_n low at rising edge):
  - state=IDLE; p0_ack=p1_ack=0; p0_rdata=p1_rdata=0.
  - Latched addr/wdata/we = 0; grant=1, so port 0 wins the first tie.
- FSM states and transitions:
  - IDLE: if any req, select winner, latch its we/addr/wdata, set grant, go ACCESS. Otherwise stay.
  - ACCESS (exactly 1 cycle): mem_addr=latched addr, mem_wdata=latched wdata, mem_we=latched we. Read: capture mem_rdata into winner's rdata register at the end of the cycle. Go RESP.
  - RESP (exactly 1 cycle): winner's ack=1, other ack=0. Go IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port not equal to grant wins (round-robin). Pointer updates only on a grant.
- Outputs outside ACCESS:
  - mem_we=0 in every state except ACCESS.
  - mem_addr/mem_wdata show latched values in all states (no glitching to the live port inputs).
- Latency:
  - req sampled high in IDLE at edge N; ack high during cycle N+2.
  - Throughput one access per 3 cycles; a single port can never starve the other.
- Requester rules:
  - Inputs are sampled only in IDLE; changes while busy are ignored.
  - Requester drops req on the edge where it samples ack=1, or keeps it high with new operands for a back-to-back access.
  - If req is still high in the IDLE cycle after RESP, it counts as a new request.
- rdata: a port's rdata register updates only on that port's read. Writes and the other port's accesses leave it unchanged.
- Reset mid-operation:
  - Reset sampled at the edge ending ACCESS of a write: the memory (no reset) still commits the write at that edge; no ack is produced.
  - Reset in RESP: the ack is cut at that edge.
  - The requester must reissue after reset.
- Address arithmetic: none. Address is passed through unmodified over the full 0..255 range.

Test Plan:
- Reset, then p0 read addr 200 (memory 200=0x05) -> mem_we=0 throughout; p0_ack high exactly cycle N+2; p0_rdata=0x05; p1_ack stays 0, p1_rdata stays 0.
- p1 write addr 100 data 0xA5, then p0 read addr 100 -> mem_we high exactly one cycle with mem_addr=100, mem_wdata=0xA5; p0_rdata=0xA5; p1_rdata still 0.
- p0 and p1 both req reads (addr 200 / 201 = 0x0A), held continuously -> grant order 0,1,0,1; acks alternate every 3 cycles; p0_rdata=0x05, p1_rdata=0x0A.
- Port 0 changes p0_addr during ACCESS -> mem_addr keeps latched value; returned data matches the originally sampled address.
- rst_n low during RESP of a p1 read -> p1_ack=0 next cycle, p1_rdata=0, state IDLE, busy=0, grant=1; next simultaneous request goes to port 0.
- p0 write addr 255 data 0xFF, p0 read 255 back-to-back with req held -> second ack 3 cycles after first; p0_rdata=0xFF.
